count_stream_decoder: RTL

- Receive side of the loadable up/down counter interface.
- Samples the counter's output value stream each cycle.
- Reconstructs the operation that produced each new value: increment, decrement or load.
- Emits one event per classified sample and keeps saturating statistics.
- Used by monitors and downstream logic that see only the count bus, not load/trigger.

---
 rtl/count_stream_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/count_stream_decoder.sv
// count_stream_decoder: receive side of a loadable up/down counter link.
// Watches the count bus, infers whether each new value came from an increment,
// a decrement or a load, emits one registered event per classified sample and
// keeps saturating statistics.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   in_valid_i   count_in_i carries a new sample
//   count_in_i   observed counter value
//   clr_i        synchronous clear of statistics and run length
//   evt_valid_o  one-cycle event strobe
//   evt_type_o   01 UP, 10 DOWN, 11 LOAD (00 only before the first event)
//   evt_data_o   sample that produced the event
//   up_cnt_o     saturating UP count
//   down_cnt_o   saturating DOWN count
//   load_cnt_o   saturating LOAD count
//   run_len_o    consecutive same-direction steps, saturating
//   synced_o     a reference sample has been captured
module count_stream_decoder #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [W-1:0]  count_in_i,
  input  logic          clr_i,
  output logic          evt_valid_o,
  output logic [1:0]    evt_type_o,
  output logic [W-1:0]  evt_data_o,
  output logic [CW-1:0] up_cnt_o,
  output logic [CW-1:0] down_cnt_o,
  output logic [CW-1:0] load_cnt_o,
  output logic [CW-1:0] run_len_o,
  output logic          synced_o
);

  localparam logic [1:0] TypeNone = 2'b00;
  localparam logic [1:0] TypeUp   = 2'b01;
  localparam logic [1:0] TypeDown = 2'b10;
  localparam logic [1:0] TypeLoad = 2'b11;

  typedef enum logic {StUnsync, StSync} state_e;

  state_e        state_q;
  logic [W-1:0]  last_q;
  // Direction of the previous step; TypeNone after sync, load or clear so the
  // next step restarts the run at 1.
  logic [1:0]    dir_q;
  logic          evt_valid_q;
  logic [1:0]    evt_type_q;
  logic [W-1:0]  evt_data_q;
  logic [CW-1:0] up_cnt_q, down_cnt_q, load_cnt_q, run_len_q;
  logic          synced_q;

  logic [1:0]    cls;
  logic [W-1:0]  last_inc, last_dec;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Modulo-2^W neighbours, so the wraps FF->00 and 00->FF count as steps.
  always_comb begin
    last_inc = last_q + W'(1);
    last_dec = last_q - W'(1);
    cls      = TypeLoad;
    if (count_in_i == last_inc) begin
      cls = TypeUp;
    end else if (count_in_i == last_dec) begin
      cls = TypeDown;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StUnsync;
      last_q      <= '0;
      dir_q       <= TypeNone;
      evt_valid_q <= 1'b0;
      evt_type_q  <= TypeNone;
      evt_data_q  <= '0;
      up_cnt_q    <= '0;
      down_cnt_q  <= '0;
      load_cnt_q  <= '0;
      run_len_q   <= '0;
      synced_q    <= 1'b0;
    end else begin
      evt_valid_q <= 1'b0;
      unique case (state_q)
        StUnsync: begin
          if (in_valid_i) begin
            last_q   <= count_in_i;
            synced_q <= 1'b1;
            dir_q    <= TypeNone;
            state_q  <= StSync;
          end
        end
        StSync: begin
          if (in_valid_i) begin
            last_q      <= count_in_i;
            evt_valid_q <= 1'b1;
            evt_type_q  <= cls;
            evt_data_q  <= count_in_i;
            if (cls == TypeLoad) begin
              load_cnt_q <= sat_inc(load_cnt_q);
              run_len_q  <= '0;
              dir_q      <= TypeNone;
            end else begin
              if (cls == TypeUp) begin
                up_cnt_q <= sat_inc(up_cnt_q);
              end else begin
                down_cnt_q <= sat_inc(down_cnt_q);
              end
              run_len_q <= (dir_q == cls) ? sat_inc(run_len_q) : CW'(1);
              dir_q     <= cls;
            end
          end
        end
        default: state_q <= StUnsync;
      endcase
      // Clear wins over any statistic update from a coincident sample.
      if (clr_i) begin
        up_cnt_q   <= '0;
        down_cnt_q <= '0;
        load_cnt_q <= '0;
        run_len_q  <= '0;
        dir_q      <= TypeNone;
      end
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_type_o  = evt_type_q;
  assign evt_data_o  = evt_data_q;
  assign up_cnt_o    = up_cnt_q;
  assign down_cnt_o  = down_cnt_q;
  assign load_cnt_o  = load_cnt_q;
  assign run_len_o   = run_len_q;
  assign synced_o    = synced_q;

endmodule
